// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, NOP encoding and fetch-stage defaults.
package pipeline_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_000C;
   localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0040_0000;
   localparam logic [31:0] INSTR_BYTES        = 32'd4;

   // Instruction addresses must sit on a word boundary.
   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage : pipeline_pkg

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction ROM (slave).
interface fetch_stage_if #(
   parameter int IMEM_ADDR_W = 5
);

   logic [IMEM_ADDR_W-1:0] IMEM_ADDR;
   logic [31:0]            IMEM_DATA;

   modport master (
      output IMEM_ADDR,
      input  IMEM_DATA
   );

   modport slave (
      input  IMEM_ADDR,
      output IMEM_DATA
   );

endinterface : fetch_stage_if

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag with load, hold and bubble controls.
module if_id_reg
   import pipeline_pkg::*;
(
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] instr_d,
   input  logic [31:0] pc4_d,
   output logic [31:0] instr_q,
   output logic [31:0] pc4_q,
   output logic        valid_q
);

   // Bubble wins over load so a flush can never be undone by a concurrent fetch.
   always_ff @(posedge CLOCK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RESET) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
      end else if (bubble) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
      end else if (load) begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= 1'b1;
      end
   end

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, addresses instruction memory and fills IF/ID.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
   parameter int          IMEM_ADDR_W = 5,
   parameter logic [31:0] HALT_INSTR  = DEFAULT_HALT_INSTR
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic                STALL,
   input  logic                BRANCH_TAKEN,
   input  logic [31:0]         BRANCH_TARGET,
   fetch_stage_if.master       imem,
   output logic [31:0]         PC,
   output logic [31:0]         IF_ID_INSTR,
   output logic [31:0]         IF_ID_PC4,
   output logic                IF_ID_VALID,
   output logic                HALTED,
   output logic                FAULT,
   output logic [15:0]         FETCH_COUNT
);

   fetch_state_t state, state_n;
   logic [31:0]  pc_n;
   logic [31:0]  pc_plus4;
   logic [15:0]  count_n;
   logic         ifid_load;
   logic         ifid_bubble;
   logic         target_ok;

   assign pc_plus4      = PC + INSTR_BYTES;
   assign target_ok     = is_word_aligned(BRANCH_TARGET);
   assign imem.IMEM_ADDR = PC[IMEM_ADDR_W+1:2];

   assign HALTED = (state == ST_HALT);
   assign FAULT  = (state == ST_FAULT);

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state       <= ST_RUN;
         PC          <= RESET_PC;
         FETCH_COUNT <= 16'd0;
      end else begin
         state       <= state_n;
         PC          <= pc_n;
         FETCH_COUNT <= count_n;
      end
   end

   // Redirect beats stall; a misaligned redirect freezes the PC and parks the stage in FAULT.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_n     = state;
      pc_n        = PC;
      count_n     = FETCH_COUNT;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;

      unique case (state)
         ST_RUN: begin
            if (BRANCH_TAKEN) begin
               ifid_bubble = 1'b1;
               if (target_ok) begin
                  pc_n = BRANCH_TARGET;
               end else begin
                  state_n = ST_FAULT;
               end
            end else if (!STALL) begin
               pc_n      = pc_plus4;
               ifid_load = 1'b1;
               count_n   = FETCH_COUNT + 16'd1;
               if (imem.IMEM_DATA == HALT_INSTR) begin
                  state_n = ST_HALT;
               end
            end
         end

         ST_HALT: begin
            ifid_bubble = 1'b1;
            if (BRANCH_TAKEN) begin
               if (target_ok) begin
                  pc_n    = BRANCH_TARGET;
                  state_n = ST_RUN;
               end else begin
                  state_n = ST_FAULT;
               end
            end
         end

         ST_FAULT: begin
            ifid_bubble = 1'b1;
         end

         default: begin
            ifid_bubble = 1'b1;
            state_n     = ST_FAULT;
         end
      endcase
   end

   if_id_reg u_if_id_reg (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .load    (ifid_load),
      .bubble  (ifid_bubble),
      .instr_d (imem.IMEM_DATA),
      .pc4_d   (pc_plus4),
      .instr_q (IF_ID_INSTR),
      .pc4_q   (IF_ID_PC4),
      .valid_q (IF_ID_VALID)
   );

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: normal fetch, stall, redirect, halt, fault and PC wrap.
module tb_fetch_stage;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        STALL;
   logic        BRANCH_TAKEN;
   logic [31:0] BRANCH_TARGET;
   logic [31:0] PC;
   logic [31:0] IF_ID_INSTR;
   logic [31:0] IF_ID_PC4;
   logic        IF_ID_VALID;
   logic        HALTED;
   logic        FAULT;
   logic [15:0] FETCH_COUNT;

   logic        rst_w;
   logic [31:0] pc_w;
   logic [31:0] instr_w;
   logic [31:0] pc4_w;
   logic        valid_w;
   logic        halted_w;
   logic        fault_w;
   logic [15:0] count_w;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLOCK = ~CLOCK;

   fetch_stage_if #(.IMEM_ADDR_W(5)) imem ();
   fetch_stage_if #(.IMEM_ADDR_W(5)) imem_w ();

   fetch_stage dut (
      .CLOCK         (CLOCK),
      .RESET         (RESET),
      .STALL         (STALL),
      .BRANCH_TAKEN  (BRANCH_TAKEN),
      .BRANCH_TARGET (BRANCH_TARGET),
      .imem          (imem.master),
      .PC            (PC),
      .IF_ID_INSTR   (IF_ID_INSTR),
      .IF_ID_PC4     (IF_ID_PC4),
      .IF_ID_VALID   (IF_ID_VALID),
      .HALTED        (HALTED),
      .FAULT         (FAULT),
      .FETCH_COUNT   (FETCH_COUNT)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .CLOCK         (CLOCK),
      .RESET         (rst_w),
      .STALL         (1'b0),
      .BRANCH_TAKEN  (1'b0),
      .BRANCH_TARGET (32'd0),
      .imem          (imem_w.master),
      .PC            (pc_w),
      .IF_ID_INSTR   (instr_w),
      .IF_ID_PC4     (pc4_w),
      .IF_ID_VALID   (valid_w),
      .HALTED        (halted_w),
      .FAULT         (fault_w),
      .FETCH_COUNT   (count_w)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle to the falling edge for sampling.
   task automatic tick();
      @(posedge CLOCK);
      @(negedge CLOCK);
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] pc_e, input logic [31:0] instr_e,
                             input logic [31:0] pc4_e, input logic valid_e, input logic [15:0] cnt_e);
      check({tag, ".pc"},    PC,                   pc_e);
      check({tag, ".instr"}, IF_ID_INSTR,          instr_e);
      check({tag, ".pc4"},   IF_ID_PC4,            pc4_e);
      check({tag, ".valid"}, {31'd0, IF_ID_VALID}, {31'd0, valid_e});
      check({tag, ".count"}, {16'd0, FETCH_COUNT}, {16'd0, cnt_e});
   endtask

   initial begin
      RESET          = 1'b1;
      rst_w          = 1'b1;
      STALL          = 1'b0;
      BRANCH_TAKEN   = 1'b0;
      BRANCH_TARGET  = 32'd0;
      imem.IMEM_DATA   = 32'd0;
      imem_w.IMEM_DATA = 32'd0;
      tick();
      tick();
      RESET = 1'b0;

      check_ifid("reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 16'd0);
      check("reset.halted", {31'd0, HALTED}, 32'd0);
      check("reset.fault",  {31'd0, FAULT},  32'd0);
      check("reset.addr",   {27'd0, imem.IMEM_ADDR}, 32'd0);

      // Normal fetch, then a two-edge stall, then the remaining two fetches.
      imem.IMEM_DATA = 32'h2008_0001;
      tick();
      check_ifid("fetch1", 32'h0040_0004, 32'h2008_0001, 32'h0040_0004, 1'b1, 16'd1);
      check("fetch1.addr", {27'd0, imem.IMEM_ADDR}, 32'd1);

      STALL          = 1'b1;
      imem.IMEM_DATA = 32'h2009_0002;
      tick();
      check_ifid("stall1", 32'h0040_0004, 32'h2008_0001, 32'h0040_0004, 1'b1, 16'd1);
      tick();
      check_ifid("stall2", 32'h0040_0004, 32'h2008_0001, 32'h0040_0004, 1'b1, 16'd1);

      STALL = 1'b0;
      tick();
      check_ifid("release", 32'h0040_0008, 32'h2009_0002, 32'h0040_0008, 1'b1, 16'd2);

      imem.IMEM_DATA = 32'h0109_5020;
      tick();
      check_ifid("fetch3", 32'h0040_000C, 32'h0109_5020, 32'h0040_000C, 1'b1, 16'd3);
      check("fetch3.addr", {27'd0, imem.IMEM_ADDR}, 32'd3);

      // Redirect with a simultaneous stall: the branch wins and inserts one bubble.
      BRANCH_TAKEN   = 1'b1;
      BRANCH_TARGET  = 32'h0040_0010;
      STALL          = 1'b1;
      imem.IMEM_DATA = 32'hDEAD_BEEF;
      tick();
      check_ifid("branch", 32'h0040_0010, 32'h0, 32'h0, 1'b0, 16'd3);

      BRANCH_TAKEN   = 1'b0;
      STALL          = 1'b0;
      imem.IMEM_DATA = 32'h8C01_0000;
      tick();
      check_ifid("target", 32'h0040_0014, 32'h8C01_0000, 32'h0040_0014, 1'b1, 16'd4);

      // SYSCALL is loaded valid, PC advances once, then fetch freezes.
      imem.IMEM_DATA = 32'h0000_000C;
      tick();
      check_ifid("syscall", 32'h0040_0018, 32'h0000_000C, 32'h0040_0018, 1'b1, 16'd5);
      check("syscall.halted", {31'd0, HALTED}, 32'd1);

      STALL          = 1'b1;
      imem.IMEM_DATA = 32'h1111_1111;
      tick();
      check_ifid("halted", 32'h0040_0018, 32'h0, 32'h0, 1'b0, 16'd5);
      check("halted.halted", {31'd0, HALTED}, 32'd1);

      STALL         = 1'b0;
      BRANCH_TAKEN  = 1'b1;
      BRANCH_TARGET = 32'h0040_0020;
      tick();
      check_ifid("unhalt", 32'h0040_0020, 32'h0, 32'h0, 1'b0, 16'd5);
      check("unhalt.halted", {31'd0, HALTED}, 32'd0);

      BRANCH_TAKEN   = 1'b0;
      imem.IMEM_DATA = 32'h2222_2222;
      tick();
      check_ifid("resume", 32'h0040_0024, 32'h2222_2222, 32'h0040_0024, 1'b1, 16'd6);

      // Misaligned target faults; only reset leaves FAULT.
      BRANCH_TAKEN  = 1'b1;
      BRANCH_TARGET = 32'h0040_0006;
      tick();
      check_ifid("fault", 32'h0040_0024, 32'h0, 32'h0, 1'b0, 16'd6);
      check("fault.fault", {31'd0, FAULT}, 32'd1);

      BRANCH_TARGET = 32'h0040_0040;
      tick();
      check_ifid("fault_hold", 32'h0040_0024, 32'h0, 32'h0, 1'b0, 16'd6);
      check("fault_hold.fault", {31'd0, FAULT}, 32'd1);

      BRANCH_TAKEN = 1'b0;
      RESET        = 1'b1;
      tick();
      RESET = 1'b0;
      check_ifid("fault_reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 16'd0);
      check("fault_reset.fault", {31'd0, FAULT}, 32'd0);

      // PC wrap from 0xFFFFFFFC on the second instance.
      check("wrap.reset_pc", pc_w, 32'hFFFF_FFFC);
      check("wrap.addr", {27'd0, imem_w.IMEM_ADDR}, 32'h1F);
      rst_w            = 1'b0;
      imem_w.IMEM_DATA = 32'h2008_0001;
      tick();
      check("wrap.pc",    pc_w,              32'h0);
      check("wrap.pc4",   pc4_w,             32'h0);
      check("wrap.instr", instr_w,           32'h2008_0001);
      check("wrap.valid", {31'd0, valid_w},  32'd1);
      check("wrap.count", {16'd0, count_w},  32'd1);
      check("wrap.flags", {30'd0, halted_w, fault_w}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_fetch_stage
